// File: rtl/data_memory_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl_if
//   Request/response bundle between the MEM stage and data_memory_ctrl.
//   master : pipeline side (drives the request, receives the response)
//   slave  : memory controller side
// Signals
//   req_valid     request present                      (master -> slave)
//   req_ready     controller can accept a request      (slave  -> master)
//   mem_read      load request                         (master -> slave)
//   mem_write     store size: 00 none/01 byte/10 half/11 word
//   load_size     01 byte/10 half/11 word (00 = word)
//   load_unsigned 1 = zero-extend sub-word loads
//   address       byte address, ADDR_W bits
//   write_data    store data, right-justified
//   resp_valid    one-cycle response strobe            (slave  -> master)
//   read_data     load result, held until next response
//   misaligned    misalignment flag, qualified by resp_valid
// ---------------------------------------------------------------------------
interface data_memory_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              mem_read;
    logic [1:0]        mem_write;
    logic [1:0]        load_size;
    logic              load_unsigned;
    logic [ADDR_W-1:0] address;
    logic [31:0]       write_data;
    logic              resp_valid;
    logic [31:0]       read_data;
    logic              misaligned;

    modport master (
        output req_valid, mem_read, mem_write, load_size, load_unsigned,
               address, write_data,
        input  req_ready, resp_valid, read_data, misaligned
    );

    modport slave (
        input  req_valid, mem_read, mem_write, load_size, load_unsigned,
               address, write_data,
        output req_ready, resp_valid, read_data, misaligned
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//   Handshaked word-array data memory for the MEM stage. Supports byte, half
//   and word stores, signed/unsigned sub-word loads and a configurable number
//   of wait states between accept and response.
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of 2, >= 4)
//   ADDR_W       byte-address width
//   WAIT_STATES  extra cycles between accept and response (0..15)
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   mem_if       data_memory_ctrl_if.slave request/response bundle
// Configuration
//   DMEM_MISALIGN_TRAP_EN  defined   : misaligned half/word accesses are
//                                      flagged, have no side effect and
//                                      return 0.
//                          undefined : low address bits below the access
//                                      size are ignored; misaligned = 0.
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    data_memory_ctrl_if.slave mem_if
);
    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] read_data_q;
    logic        misaligned_q;

    // Request captured at accept
    logic             rd_q;
    logic [1:0]       wr_q;
    logic [1:0]       lsize_q;
    logic             uns_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       off_q;
    logic [31:0]      wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_if.address[ADDR_W-1:IDX_W+2];

    logic accept;
    logic enter_resp;
    assign accept     = (state_q == ST_IDLE) && mem_if.req_valid;
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_if.req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath. With WAIT_STATES=0 the RESP edge is the accept edge, so the
    // live inputs are used in IDLE and the captured copy afterwards.
    // ---------------------------------------------------------------------
    logic             cur_rd;
    logic [1:0]       cur_wr;
    logic [1:0]       cur_lsize;
    logic             cur_uns;
    logic [IDX_W-1:0] cur_idx;
    logic [1:0]       cur_off;
    logic [31:0]      cur_wdata;
    logic [31:0]      old_word;
    logic [3:0]       be;
    logic [31:0]      lanes;
    logic [31:0]      merged;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_val;
    logic [31:0]      resp_data;
    logic             mis;
    logic             do_store;

    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_rd    = mem_if.mem_read;
            cur_wr    = mem_if.mem_write;
            cur_lsize = mem_if.load_size;
            cur_uns   = mem_if.load_unsigned;
            cur_idx   = mem_if.address[IDX_W+1:2];
            cur_off   = mem_if.address[1:0];
            cur_wdata = mem_if.write_data;
        end else begin
            cur_rd    = rd_q;
            cur_wr    = wr_q;
            cur_lsize = lsize_q;
            cur_uns   = uns_q;
            cur_idx   = idx_q;
            cur_off   = off_q;
            cur_wdata = wdata_q;
        end
    end

    assign old_word = mem[cur_idx];

    always_comb begin
        be    = 4'b0000;
        lanes = cur_wdata;
        case (cur_wr)
            2'b01: begin
                be    = 4'b0001 << cur_off;
                lanes = {4{cur_wdata[7:0]}};
            end
            2'b10: begin
                be    = cur_off[1] ? 4'b1100 : 4'b0011;
                lanes = {2{cur_wdata[15:0]}};
            end
            2'b11:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? lanes[8*b +: 8] : old_word[8*b +: 8];
        end
    end

    // Load extraction works on the pre-store word, so read+write returns
    // the old contents.
    always_comb begin
        ld_byte = old_word[{cur_off, 3'b000} +: 8];
        ld_half = cur_off[1] ? old_word[31:16] : old_word[15:0];
        case (cur_lsize)
            2'b01:   load_val = {{24{ld_byte[7]  & ~cur_uns}}, ld_byte};
            2'b10:   load_val = {{16{ld_half[15] & ~cur_uns}}, ld_half};
            default: load_val = old_word;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic st_mis;
    logic ld_mis;
    assign st_mis = ((cur_wr == 2'b10) && cur_off[0]) ||
                    ((cur_wr == 2'b11) && (cur_off != 2'b00));
    assign ld_mis = cur_rd &&
                    (((cur_lsize == 2'b10) && cur_off[0]) ||
                     (((cur_lsize == 2'b11) || (cur_lsize == 2'b00)) && (cur_off != 2'b00)));
    // A trapped access has no side effect on the array at all.
    assign mis    = st_mis || ld_mis;
`else
    assign mis    = 1'b0;
`endif

    assign do_store  = (cur_wr != 2'b00) && !mis;
    assign resp_data = (cur_rd && !mis) ? load_val : 32'd0;

    // ---------------------------------------------------------------------
    // State and response registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs, independent of block order.
        if (rst) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 4'd0;
            read_data_q  <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (enter_resp) begin
                read_data_q  <= resp_data;
                misaligned_q <= mis;
            end
        end
    end

    // Request capture; only consulted while the FSM is past IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q    <= mem_if.mem_read;
            wr_q    <= mem_if.mem_write;
            lsize_q <= mem_if.load_size;
            uns_q   <= mem_if.load_unsigned;
            idx_q   <= mem_if.address[IDX_W+1:2];
            off_q   <= mem_if.address[1:0];
            wdata_q <= mem_if.write_data;
        end
    end

    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into a large register file. A reset aborting a request blocks the store.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && do_store) begin
            mem[cur_idx] <= merged;
        end
    end

    assign mem_if.req_ready  = (state_q == ST_IDLE);
    assign mem_if.resp_valid = (state_q == ST_RESP);
    assign mem_if.read_data  = read_data_q;
    assign mem_if.misaligned = misaligned_q;
endmodule
